// File: rtl/bicintp_feed.sv
// bicintp_feed: front-end sequencer for the bicubic interpolation datapath.
// Takes one output-pixel request, issues 4 contiguous line-buffer reads
// (columns x-1..x+2) and presents Keys-cubic (a=-0.5) tap weights to the
// calculator, aligned with the RAM read data RAM_LAT cycles later.
// Optional build macro BICINTP_FEED_EDGE_MIRROR_EN selects reflect-without-
// repeat border handling; when undefined, out-of-line columns are clamped.
module bicintp_feed #(
  parameter int ADDR_W  = 12,
  parameter int FRAC_W  = 4,
  parameter int RAM_LAT = 1
)(
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [ADDR_W-1:0] req_x_int,
  input  logic [FRAC_W-1:0] req_x_frac,
  input  logic [FRAC_W-1:0] req_y_frac,
  input  logic [ADDR_W-1:0] line_w,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              intp_enb,
  output logic [7:0]        w_x,
  output logic [7:0]        w_y_0,
  output logic [7:0]        w_y_1,
  output logic [7:0]        w_y_2,
  output logic [7:0]        w_y_3,
  output logic              busy
);

  localparam int NPH = 1 << FRAC_W;
  // Two guard bits: x_int+2 and 2*(W-1) must not overflow the signed column.
  localparam int CW  = ADDR_W + 2;
  localparam logic signed [CW-1:0] ONE = 1;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] x_int;
    logic [FRAC_W-1:0] x_frac;
    logic [FRAC_W-1:0] y_frac;
  } req_t;

  // ---------------------------------------------------------------------
  // Kernel table, built at elaboration from the Keys cubic.
  // Distance n is in units of 1/NPH; weights are x128, rounded half-up.
  // ---------------------------------------------------------------------
  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int keys_w(input int n);
    longint s, s3, nn, num;
    s  = longint'(NPH);
    s3 = s * s * s;
    nn = longint'(n);
    if (nn <= s)
      num = 192*nn*nn*nn - 320*nn*nn*s + 128*s3;
    else if (nn < 2*s)
      num = -64*nn*nn*nn + 320*nn*nn*s - 512*nn*s*s + 256*s3;
    else
      num = 0;
    return int'(fdiv(num + s3/2, s3));
  endfunction

  function automatic logic [NPH*32-1:0] build_lut();
    logic [NPH*32-1:0] r;
    int t0, t1, t2, t3;
    r = '0;
    for (int p = 0; p < NPH; p++) begin
      t0 = keys_w(NPH + p);
      t2 = keys_w(NPH - p);
      t3 = keys_w(2*NPH - p);
      // Centre tap absorbs rounding so every phase sums to exactly 128.
      t1 = 128 - (t0 + t2 + t3);
      r[(p*4+0)*8 +: 8] = 8'(t0);
      r[(p*4+1)*8 +: 8] = 8'(t1);
      r[(p*4+2)*8 +: 8] = 8'(t2);
      r[(p*4+3)*8 +: 8] = 8'(t3);
    end
    return r;
  endfunction

  localparam logic [NPH*32-1:0] KLUT = build_lut();

  function automatic logic [7:0] lut(input logic [FRAC_W-1:0] ph, input logic [1:0] k);
    return KLUT[int'({ph, k})*8 +: 8];
  endfunction

  // Source column of tap k: x_int - 1 + k, signed so the left edge goes negative.
  function automatic logic signed [CW-1:0] col_of(input logic [ADDR_W-1:0] x, input logic [1:0] k);
    logic signed [CW-1:0] c;
    c = $signed({2'b00, x}) + $signed({{(CW-2){1'b0}}, k}) - ONE;
    return c;
  endfunction

  // Fold an out-of-line column back into 0..W-1.
  function automatic logic [ADDR_W-1:0] border(input logic signed [CW-1:0] c,
                                               input logic [ADDR_W-1:0] w);
    logic signed [CW-1:0] wm1, r;
    wm1 = $signed({2'b00, w}) - ONE;
`ifdef BICINTP_FEED_EDGE_MIRROR_EN
    if (c < 0)        r = -c;
    else if (c > wm1) r = (wm1 <<< 1) - c;
    else              r = c;
`else
    if (c < 0)        r = '0;
    else if (c > wm1) r = wm1;
    else              r = c;
`endif
    return r[ADDR_W-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // Sequencer state and the RAM-latency alignment pipe.
  // Stage 0 is the issue cycle (ram_rd_en); stage RAM_LAT meets p0..p3.
  // ---------------------------------------------------------------------
  state_t                   state;
  logic [1:0]               k;
  req_t                     cap;
  logic [RAM_LAT:0]         vld_pipe;
  logic [RAM_LAT-1:0]       first_pipe;
  logic [RAM_LAT:0][7:0]    wx_pipe;
  logic                     accept;

  assign req_rdy   = (state == IDLE) | ((state == RUN) & (k == 2'd3));
  assign accept    = req_vld & req_rdy;
  assign ram_rd_en = vld_pipe[0];
  assign intp_enb  = vld_pipe[RAM_LAT];
  assign w_x       = wx_pipe[RAM_LAT];
  assign busy      = |vld_pipe;

  // FSM: capture on accept, step k=0..3 issuing reads, chain the next group with no bubble.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state       <= IDLE;
      k           <= 2'd0;
      cap         <= '0;
      ram_rd_addr <= '0;
      vld_pipe    <= '0;
      first_pipe  <= '0;
      wx_pipe     <= '0;
    end else begin
      if (accept) begin
        state         <= RUN;
        k             <= 2'd0;
        cap           <= '{x_int: req_x_int, x_frac: req_x_frac, y_frac: req_y_frac};
        ram_rd_addr   <= border(col_of(req_x_int, 2'd0), line_w);
        vld_pipe[0]   <= 1'b1;
        first_pipe[0] <= 1'b1;
        wx_pipe[0]    <= lut(req_x_frac, 2'd0);
      end else if ((state == RUN) && (k != 2'd3)) begin
        k             <= k + 2'd1;
        ram_rd_addr   <= border(col_of(cap.x_int, k + 2'd1), line_w);
        vld_pipe[0]   <= 1'b1;
        first_pipe[0] <= 1'b0;
        wx_pipe[0]    <= lut(cap.x_frac, k + 2'd1);
      end else begin
        state         <= IDLE;
        vld_pipe[0]   <= 1'b0;
        first_pipe[0] <= 1'b0;
        wx_pipe[0]    <= 8'h00;
      end
      for (int i = 1; i <= RAM_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        wx_pipe[i]  <= wx_pipe[i-1];
      end
      for (int i = 1; i < RAM_LAT; i++) first_pipe[i] <= first_pipe[i-1];
    end
  end

  // Vertical weights: load on the group's first tap, hold until the next group's first tap.
  // cap.y_frac is still this group's phase here: the next accept is >= 4 cycles after
  // this one, and RAM_LAT <= 3.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      w_y_0 <= 8'h00;
      w_y_1 <= 8'h00;
      w_y_2 <= 8'h00;
      w_y_3 <= 8'h00;
    end else if (first_pipe[RAM_LAT-1]) begin
      w_y_0 <= lut(cap.y_frac, 2'd0);
      w_y_1 <= lut(cap.y_frac, 2'd1);
      w_y_2 <= lut(cap.y_frac, 2'd2);
      w_y_3 <= lut(cap.y_frac, 2'd3);
    end
  end

endmodule

// File: tb/tb_bicintp_feed.sv
// Directed bench for bicintp_feed: reset state, zero/half/quarter phases,
// left/right borders (clamp or mirror build), back-to-back groups and
// reset asserted mid-group. Taps are logged on the falling edge.
module tb_bicintp_feed;
  localparam int ADDR_W  = 12;
  localparam int FRAC_W  = 4;
  localparam int RAM_LAT = 1;

  logic              sys_clk = 1'b0;
  logic              sys_rstn = 1'b0;
  logic              req_vld = 1'b0;
  logic              req_rdy;
  logic [ADDR_W-1:0] req_x_int = '0;
  logic [FRAC_W-1:0] req_x_frac = '0;
  logic [FRAC_W-1:0] req_y_frac = '0;
  logic [ADDR_W-1:0] line_w = 12'd640;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic              intp_enb;
  logic [7:0]        w_x, w_y_0, w_y_1, w_y_2, w_y_3;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [7:0]        wx_q[$];
  logic [31:0]       wy_q[$];
  int                rd_cyc[$];
  int                en_cyc[$];

  bicintp_feed #(.ADDR_W(ADDR_W), .FRAC_W(FRAC_W), .RAM_LAT(RAM_LAT)) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_x_int(req_x_int), .req_x_frac(req_x_frac), .req_y_frac(req_y_frac),
    .line_w(line_w),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .intp_enb(intp_enb), .w_x(w_x),
    .w_y_0(w_y_0), .w_y_1(w_y_1), .w_y_2(w_y_2), .w_y_3(w_y_3),
    .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Log reads and taps away from the active edge.
  always @(negedge sys_clk) begin
    if (sys_rstn) begin
      if (ram_rd_en) begin
        addr_q.push_back(ram_rd_addr);
        rd_cyc.push_back(cyc);
      end
      if (intp_enb) begin
        wx_q.push_back(w_x);
        wy_q.push_back({w_y_0, w_y_1, w_y_2, w_y_3});
        en_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    addr_q.delete(); wx_q.delete(); wy_q.delete(); rd_cyc.delete(); en_cyc.delete();
  endtask

  // Called at posedge+1; returns the cycle number seen just after the accepting edge.
  task automatic send(input int x, input int xf, input int yf, output int acc);
    int t;
    req_vld = 1'b1;
    req_x_int = ADDR_W'(x);
    req_x_frac = FRAC_W'(xf);
    req_y_frac = FRAC_W'(yf);
    t = 0;
    while (!req_rdy && t < 20) begin
      @(posedge sys_clk); #1;
      t++;
    end
    chk("rdy_timeout", 32'(t < 20), 32'd1);
    @(posedge sys_clk); #1;
    acc = cyc;
    req_vld = 1'b0;
  endtask

  task automatic flush();
    repeat (RAM_LAT + 6) @(posedge sys_clk);
    #1;
  endtask

  // Pop one 4-tap group and compare addresses, weights and timing.
  task automatic expect_group(input string tag, input int acc, input logic [47:0] ea,
                              input logic [31:0] ewx, input logic [31:0] ewy);
    chk({tag, "_nrd"}, 32'(addr_q.size() >= 4), 32'd1);
    chk({tag, "_nen"}, 32'(en_cyc.size() >= 4), 32'd1);
    if (addr_q.size() >= 4 && en_cyc.size() >= 4) begin
      chk({tag, "_rdlat"}, 32'(rd_cyc[0] - acc), 32'd0);
      chk({tag, "_enlat"}, 32'(en_cyc[0] - acc), 32'(RAM_LAT));
      chk({tag, "_enrun"}, 32'(en_cyc[3] - en_cyc[0]), 32'd3);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s_addr%0d", tag, k), 32'(addr_q.pop_front()), 32'(ea[47-12*k -: 12]));
        chk($sformatf("%s_wx%0d", tag, k), 32'(wx_q.pop_front()), 32'(ewx[31-8*k -: 8]));
        chk($sformatf("%s_wy%0d", tag, k), wy_q.pop_front(), ewy);
        void'(rd_cyc.pop_front());
        void'(en_cyc.pop_front());
      end
    end
  endtask

  initial begin
    int a0, a1, a2;
    logic [47:0] e_left, e_right;
`ifdef BICINTP_FEED_EDGE_MIRROR_EN
    e_left  = {12'd1, 12'd0, 12'd1, 12'd2};
    e_right = {12'd638, 12'd639, 12'd638, 12'd637};
`else
    e_left  = {12'd0, 12'd0, 12'd1, 12'd2};
    e_right = {12'd638, 12'd639, 12'd639, 12'd639};
`endif

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_rdy", 32'(req_rdy), 32'd1);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_enb", 32'(intp_enb), 32'd0);
    chk("rst_wx", 32'(w_x), 32'd0);
    chk("rst_wy", {w_y_0, w_y_1, w_y_2, w_y_3}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge sys_clk) sys_rstn = 1'b1;
    @(posedge sys_clk); #1;

    // Zero phase
    send(10, 0, 0, a0); flush();
    expect_group("zero", a0, {12'd9, 12'd10, 12'd11, 12'd12}, 32'h00800000, 32'h00800000);

    // Half phase
    send(100, 8, 8, a0); flush();
    expect_group("half", a0, {12'd99, 12'd100, 12'd101, 12'd102}, 32'hF84848F8, 32'hF84848F8);

    // Borders
    send(0, 0, 0, a0); flush();
    expect_group("left", a0, e_left, 32'h00800000, 32'h00800000);
    send(639, 0, 0, a0); flush();
    expect_group("right", a0, e_right, 32'h00800000, 32'h00800000);

    // Back-to-back, no bubble between groups
    send(20, 8, 0, a0);
    send(300, 0, 8, a1);
    send(500, 4, 4, a2);
    flush();
    chk("b2b_gap1", 32'(a1 - a0), 32'd4);
    chk("b2b_gap2", 32'(a2 - a1), 32'd4);
    chk("b2b_nen", 32'(en_cyc.size()), 32'd12);
    if (en_cyc.size() == 12) chk("b2b_contig", 32'(en_cyc[11] - en_cyc[0]), 32'd11);
    expect_group("b2b0", a0, {12'd19, 12'd20, 12'd21, 12'd22}, 32'hF84848F8, 32'h00800000);
    expect_group("b2b1", a1, {12'd299, 12'd300, 12'd301, 12'd302}, 32'h00800000, 32'hF84848F8);
    expect_group("b2b2", a2, {12'd499, 12'd500, 12'd501, 12'd502}, 32'hF76F1DFD, 32'hF76F1DFD);

    // Reset at tap k=1: outputs clear at once, nothing resumes after release
    send(50, 8, 8, a0);
    @(posedge sys_clk); #1;
    sys_rstn = 1'b0;
    #1;
    chk("mid_rd_en", 32'(ram_rd_en), 32'd0);
    chk("mid_enb", 32'(intp_enb), 32'd0);
    chk("mid_wx", 32'(w_x), 32'd0);
    chk("mid_wy", {w_y_0, w_y_1, w_y_2, w_y_3}, 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rdy", 32'(req_rdy), 32'd1);
    clear_q();
    @(negedge sys_clk) sys_rstn = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1;
    chk("post_rst_nrd", 32'(addr_q.size()), 32'd0);
    chk("post_rst_nen", 32'(en_cyc.size()), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Recovery with a quarter phase
    send(10, 4, 0, a0); flush();
    expect_group("recov", a0, {12'd9, 12'd10, 12'd11, 12'd12}, 32'hF76F1DFD, 32'h00800000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
